// File: rtl/seg7_reader.sv
// Seven-segment display reader: debounces the segment pattern, decodes it to a
// digit and checks that accepted digits follow a counting sequence.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       bad_pattern,
  output logic       seq_err,
  output logic [3:0] err_count,
  output logic       locked
);

  typedef enum logic {UNLOCKED, TRACK} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  state_t     state, state_nxt;
  logic [6:0] seg_q;
  logic [3:0] run_cnt, run_cnt_nxt;
  logic [3:0] digit_nxt, err_nxt;
  logic       dv_nxt, bad_nxt, seq_nxt;
  logic       eval;
  logic [4:0] dec;

  // {valid, digit}; exact match only
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] succ(input logic [3:0] d);
    succ = (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_comb begin
    run_cnt_nxt = 4'd1;
    if (segments == seg_q)
      run_cnt_nxt = (run_cnt >= STABLE) ? STABLE : run_cnt + 4'd1;
    // a run is judged only on the edge its count first reaches STABLE
    eval      = (run_cnt_nxt == STABLE) && (run_cnt != STABLE);
    dec       = decode(segments);
    state_nxt = state;
    digit_nxt = digit;
    err_nxt   = err_count;
    dv_nxt    = 1'b0;
    bad_nxt   = 1'b0;
    seq_nxt   = 1'b0;
    if (eval) begin
      if (dec[4]) begin
        dv_nxt    = 1'b1;
        digit_nxt = dec[3:0];
        state_nxt = TRACK;
        if (state == TRACK && dec[3:0] != succ(digit) && dec[3:0] != digit) begin
          seq_nxt = 1'b1;
          err_nxt = sat_inc(err_count);
        end
      end else begin
        bad_nxt = 1'b1;
        err_nxt = sat_inc(err_count);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q       <= '0;
      run_cnt     <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      bad_pattern <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      seg_q       <= segments;
      run_cnt     <= run_cnt_nxt;
      digit       <= digit_nxt;
      digit_valid <= dv_nxt;
      bad_pattern <= bad_nxt;
      seq_err     <= seq_nxt;
      err_count   <= err_nxt;
    end
  end

  assign locked = (state == TRACK);

endmodule
